mem_req_arbiter: RTL

- Shares the single SRAM-like memory port of the CPU core between two requesters.
  - Instruction fetch side: read-only.
  - Data memory side: load/store.
- Sits between the pipeline's fetch/mem stages and the AXI bridge.
- Sequences exactly one outstanding transaction at a time and routes handshakes and read data back to the owner.

---
 rtl/mem_req_arbiter_pkg.sv | 42 ++++
 rtl/mem_req_arbiter_pick.sv | 58 +++++
 rtl/mem_req_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_arb_pkg
//  Description : Shared encodings for the instruction/data memory-port
//                arbiter: FSM state, transaction owner and access size.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter sequencing state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

  // Which requester currently owns the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_e;

  // Access size encodings shared with the bridge
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Encoding 3 is not a legal size; fold it to a word access so the bridge
  // only ever sees one of the three defined encodings.
  function automatic logic [1:0] legal_size(input logic [1:0] sz);
    logic [1:0] res;
    case (sz)
      SZ_BYTE: res = SZ_BYTE;
      SZ_HALF: res = SZ_HALF;
      default: res = SZ_WORD;
    endcase
    return res;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_req_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational grant selector for the memory-port arbiter.
//                Holds the whole arbitration policy so the sequencing FSM
//                does not depend on it.
//  Revision    : 1.0  initial release
//
//  Configuration macro:
//    ARB_ROUND_ROBIN_EN  defined   -> on a tie, grant the side that did not
//                                     win the previous grant
//                        undefined -> data side always beats fetch side
//
//  Ports:
//    inst_req   in   fetch request pending
//    data_req   in   data request pending
//    last_data  in   1 = data side won the previous grant
//    grant      out  winner (arb_owner_e encoding, OWN_NONE if idle)
// ============================================================================
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       last_data,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = OWN_NONE;
    if (inst_req && data_req) begin
      // Tie: hand the port to whoever lost last time.
      grant = last_data ? OWN_INST : OWN_DATA;
    end else if (data_req) begin
      grant = OWN_DATA;
    end else if (inst_req) begin
      grant = OWN_INST;
    end
  end
`else
  // Fixed priority has no history; the input exists only to keep the
  // interface identical across both builds.
  logic unused_last_data;
  assign unused_last_data = last_data;

  always_comb begin
    grant = OWN_NONE;
    if (data_req) begin
      grant = OWN_DATA;
    end else if (inst_req) begin
      grant = OWN_INST;
    end
  end
`endif

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Shares the core's single SRAM-like memory port between the
//                instruction-fetch side (read only) and the data side
//                (load/store). One transaction is in flight at a time; the
//                address and data handshakes plus read data are routed back
//                to the side that owns the transaction.
//  Revision    : 1.0  initial release
//
//  Configuration macro:
//    ARB_ROUND_ROBIN_EN  alternate grants on simultaneous requests
//                        (default: data side has fixed priority)
//
//  Ports:
//    clk, rst                 clock, asynchronous active-low reset
//    inst_req/addr            fetch request and address
//    inst_addr_ok/data_ok     fetch handshakes, inst_rdata fetch data
//    data_req/wr/size/addr/wdata  data-side request fields
//    data_addr_ok/data_ok     data handshakes, data_rdata load data
//    mem_req/wr/size/addr/wdata   registered request toward the bridge
//    mem_addr_ok/data_ok/rdata    bridge responses
//    busy                     transaction in flight
// ============================================================================
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // bridge side
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  arb_owner_e        r_owner;
  logic [1:0]        w_grant;
  logic              w_take;
  logic              w_last_data;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  // --------------------------------------------------------------------------
  // Arbitration history (only kept when alternating grants)
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_data;  // 0 = fetch won last (reset value), 1 = data won last

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_data <= 1'b0;
    end else if (w_take) begin
      r_last_data <= (w_grant == OWN_DATA);
    end
  end

  assign w_last_data = r_last_data;
`else
  assign w_last_data = 1'b0;
`endif

  arb_pick u_pick (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_data (w_last_data),
    .grant     (w_grant)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake strobes. Bridge responses are only honoured in
  // the state that expects them; anything else is dropped silently.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant != OWN_NONE) begin
          w_take      = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (mem_addr_ok) begin
          inst_addr_ok = (r_owner == OWN_INST);
          data_addr_ok = (r_owner == OWN_DATA);
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          inst_data_ok = (r_owner == OWN_INST);
          data_data_ok = (r_owner == OWN_DATA);
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch toward the bridge, owner tracking and read-data holding
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_size     <= 2'd0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      r_owner      <= OWN_NONE;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_take) begin
        mem_req <= 1'b1;
        r_owner <= arb_owner_e'(w_grant);
        if (w_grant == OWN_DATA) begin
          mem_wr    <= data_wr;
          mem_size  <= legal_size(data_size);
          mem_addr  <= data_addr;
          mem_wdata <= data_wdata;
        end else begin
          // Fetches are always full-word reads.
          mem_wr    <= 1'b0;
          mem_size  <= SZ_WORD;
          mem_addr  <= inst_addr;
          mem_wdata <= '0;
        end
      end

      if (r_state == S_ADDR && mem_addr_ok) begin
        mem_req <= 1'b0;
      end

      if (r_state == S_DATA && mem_data_ok) begin
        r_owner <= OWN_NONE;
      end

      if (inst_data_ok) begin
        r_inst_rdata <= mem_rdata;
      end
      if (data_data_ok) begin
        r_data_rdata <= mem_rdata;
      end
    end
  end

  // The owner sees fresh data in the data_ok cycle itself; otherwise each
  // side keeps showing the last word it received.
  assign inst_rdata = inst_data_ok ? mem_rdata : r_inst_rdata;
  assign data_rdata = data_data_ok ? mem_rdata : r_data_rdata;

  assign busy = (r_state != S_IDLE);

endmodule : mem_req_arbiter
`default_nettype wire
